// File: rtl/debug_sequencer_pkg.sv
// Shared encodings and sizes for the debug-port control sequencer.
package debug_sequencer_pkg;

  localparam int unsigned OP_WIDTH        = 3;
  localparam int unsigned TMR_WIDTH       = 4;
  localparam int unsigned DBG_MEM_TIMEOUT = 15;

  // Debug operation codes as presented on DEBUG_OPX.
  typedef enum logic [OP_WIDTH-1:0] {
    DEBUG_OP_NOP     = 3'd0,
    DEBUG_OP_LD_ADDR = 3'd1,
    DEBUG_OP_RD_MEM  = 3'd2,
    DEBUG_OP_WR_MEM  = 3'd3,
    DEBUG_OP_RD_SRC  = 3'd4,
    DEBUG_OP_STEP    = 3'd5,
    DEBUG_OP_RESUME  = 3'd6,
    DEBUG_OP_RSVD    = 3'd7
  } debug_op_e;

  // Sequencer states.
  typedef enum logic [3:0] {
    DBGSEQ_RUN          = 4'd0,
    DBGSEQ_STOPPING     = 4'd1,
    DBGSEQ_HALTED       = 4'd2,
    DBGSEQ_EXEC         = 4'd3,
    DBGSEQ_MEM          = 4'd4,
    DBGSEQ_POST         = 4'd5,
    DBGSEQ_ACK          = 4'd6,
    DBGSEQ_WAIT_REQ_LOW = 4'd7,
    DBGSEQ_STEP         = 4'd8
  } dbgseq_state_e;

endpackage

// File: rtl/debug_sequencer_if.sv
// Debug port, core and memory control signals seen by the sequencer.
interface debug_sequencer_if;
  import debug_sequencer_pkg::*;

  logic                DEBUG_STOPX;
  logic                DEBUG_REQX;
  logic [OP_WIDTH-1:0] DEBUG_OPX;
  logic                DEBUG_ACKX;
  logic                DEBUG_ADDR_LDX;
  logic                DEBUG_ADDR_INCX;
  logic                DEBUG_DOUT_LDX;
  logic                CPU_INSTR_DONE;
  logic                CPU_HALT;
  logic                BUS_GRANT;
  logic                MEM_RD;
  logic                MEM_WR;
  logic                MEM_READY;
  logic                DEBUG_HALTED;
  logic                DEBUG_ERR;

  // Sequencer side.
  modport slave (
    input  DEBUG_STOPX, DEBUG_REQX, DEBUG_OPX, CPU_INSTR_DONE, MEM_READY,
    output DEBUG_ACKX, DEBUG_ADDR_LDX, DEBUG_ADDR_INCX, DEBUG_DOUT_LDX,
           CPU_HALT, BUS_GRANT, MEM_RD, MEM_WR, DEBUG_HALTED, DEBUG_ERR
  );

  // Debug port / core / memory side.
  modport master (
    output DEBUG_STOPX, DEBUG_REQX, DEBUG_OPX, CPU_INSTR_DONE, MEM_READY,
    input  DEBUG_ACKX, DEBUG_ADDR_LDX, DEBUG_ADDR_INCX, DEBUG_DOUT_LDX,
           CPU_HALT, BUS_GRANT, MEM_RD, MEM_WR, DEBUG_HALTED, DEBUG_ERR
  );

endinterface

// File: rtl/dbg_timeout_counter.sv
// Down-counter with load; flags expiry once the count has reached zero.
module dbg_timeout_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
    exp_d = (cnt_d == '0);
  end

  // Count and expiry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/debug_sequencer.sv
// Halts the CPU for the debug port and runs one debug operation per handshake.
module debug_sequencer
  import debug_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DBG_MEM_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESET,
  debug_sequencer_if.slave bus
);

  localparam logic [TMR_WIDTH-1:0] TMR_LOAD = TMR_WIDTH'(MEM_TIMEOUT - 1);

  dbgseq_state_e state_q, state_d;
  debug_op_e     op_q, op_d;
  logic          resume_q, resume_d;
  logic          err_q, err_d;
  logic          halt_q, halt_d;
  logic          ack_q, ack_d;
  logic          addr_ld_q, addr_ld_d;
  logic          addr_inc_q, addr_inc_d;
  logic          dout_ld_q, dout_ld_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          tmr_load, tmr_dec, tmr_expired;

  dbg_timeout_counter #(.WIDTH(TMR_WIDTH)) u_timeout (
    .clk        (CLK),
    .rst_n      (RESET),
    .load_i     (tmr_load),
    .load_val_i (TMR_LOAD),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_expired)
  );

  // Next state, then registered outputs decoded from the state being entered.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    resume_d = resume_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      DBGSEQ_RUN: begin
        if (bus.DEBUG_STOPX) state_d = DBGSEQ_STOPPING;
      end
      DBGSEQ_STOPPING: begin
        if (bus.CPU_INSTR_DONE)    state_d = DBGSEQ_HALTED;
        else if (!bus.DEBUG_STOPX) state_d = DBGSEQ_RUN;
      end
      DBGSEQ_HALTED: begin
        if (bus.DEBUG_REQX) begin
          op_d     = debug_op_e'(bus.DEBUG_OPX);
          err_d    = 1'b0;
          resume_d = 1'b0;
          state_d  = DBGSEQ_EXEC;
        end
      end
      DBGSEQ_EXEC: begin
        unique case (op_q)
          DEBUG_OP_LD_ADDR, DEBUG_OP_RD_SRC: state_d = DBGSEQ_POST;
          DEBUG_OP_RD_MEM, DEBUG_OP_WR_MEM: begin
            tmr_load = 1'b1;
            state_d  = DBGSEQ_MEM;
          end
          DEBUG_OP_STEP: state_d = DBGSEQ_STEP;
          DEBUG_OP_RESUME: begin
            resume_d = !bus.DEBUG_STOPX;
            state_d  = DBGSEQ_ACK;
          end
          default: state_d = DBGSEQ_ACK;
        endcase
      end
      DBGSEQ_MEM: begin
        // READY wins over expiry when both land in the same cycle.
        tmr_dec = 1'b1;
        if (bus.MEM_READY) begin
          state_d = DBGSEQ_POST;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = DBGSEQ_ACK;
        end
      end
      DBGSEQ_POST: state_d = DBGSEQ_ACK;
      DBGSEQ_ACK:  state_d = DBGSEQ_WAIT_REQ_LOW;
      DBGSEQ_WAIT_REQ_LOW: begin
        if (!bus.DEBUG_REQX) state_d = resume_q ? DBGSEQ_RUN : DBGSEQ_HALTED;
      end
      DBGSEQ_STEP: begin
        if (bus.CPU_INSTR_DONE) state_d = DBGSEQ_ACK;
      end
      default: state_d = DBGSEQ_RUN;
    endcase

    halt_d     = !(state_d inside {DBGSEQ_RUN, DBGSEQ_STOPPING, DBGSEQ_STEP});
    ack_d      = (state_d == DBGSEQ_ACK);
    addr_ld_d  = (state_d == DBGSEQ_POST) && (op_q == DEBUG_OP_LD_ADDR);
    addr_inc_d = (state_d == DBGSEQ_POST) &&
                 ((op_q == DEBUG_OP_RD_MEM) || (op_q == DEBUG_OP_WR_MEM));
    dout_ld_d  = (state_d == DBGSEQ_POST) && (op_q == DEBUG_OP_RD_SRC);
    mem_rd_d   = (state_d == DBGSEQ_MEM) && (op_q == DEBUG_OP_RD_MEM);
    mem_wr_d   = (state_d == DBGSEQ_MEM) && (op_q == DEBUG_OP_WR_MEM);
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= DBGSEQ_RUN;
      op_q       <= DEBUG_OP_NOP;
      resume_q   <= 1'b0;
      err_q      <= 1'b0;
      halt_q     <= 1'b0;
      ack_q      <= 1'b0;
      addr_ld_q  <= 1'b0;
      addr_inc_q <= 1'b0;
      dout_ld_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      resume_q   <= resume_d;
      err_q      <= err_d;
      halt_q     <= halt_d;
      ack_q      <= ack_d;
      addr_ld_q  <= addr_ld_d;
      addr_inc_q <= addr_inc_d;
      dout_ld_q  <= dout_ld_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  // Read data is captured in the READY cycle itself, so that strobe is gated by READY.
  assign bus.DEBUG_DOUT_LDX  = dout_ld_q | (mem_rd_q & bus.MEM_READY);
  assign bus.DEBUG_ACKX      = ack_q;
  assign bus.DEBUG_ADDR_LDX  = addr_ld_q;
  assign bus.DEBUG_ADDR_INCX = addr_inc_q;
  assign bus.CPU_HALT        = halt_q;
  assign bus.BUS_GRANT       = halt_q;
  assign bus.DEBUG_HALTED    = halt_q;
  assign bus.MEM_RD          = mem_rd_q;
  assign bus.MEM_WR          = mem_wr_q;
  assign bus.DEBUG_ERR       = err_q;

endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Control sequencer behind the 8-bit debug port.
- Halts the CPU at an instruction boundary on a stop request and takes ownership of the memory bus.
- Executes one debug operation per request/acknowledge handshake: address load, memory read/write with address auto-increment, source capture, single-step or resume.
- Drives the port's ADDR_LDX/ADDR_INCX/DOUT_LDX/ACKX strobes and the core's halt and bus-grant controls.

Parameters:
- MEM_TIMEOUT, 15, cycles to wait for MEM_READY before aborting a memory operation (4-bit counter).
- OP_WIDTH, 3, width of the debug opcode.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- DEBUG_STOPX  in  1  synchronised stop request from the debug port; level.
- DEBUG_REQX  in  1  operation request from the debug port; level, held until ACK seen.
- DEBUG_OPX  in  3  operation code, valid while DEBUG_REQX high.
- DEBUG_ACKX  out  1  one-cycle operation-complete pulse.
- DEBUG_ADDR_LDX  out  1  load debug address counter from buffer.
- DEBUG_ADDR_INCX  out  1  increment debug address counter.
- DEBUG_DOUT_LDX  out  1  capture selected source into debug data-out register.
- CPU_INSTR_DONE  in  1  core at instruction boundary this cycle.
- CPU_HALT  out  1  freeze instruction phase decoder.
- BUS_GRANT  out  1  memory address/data muxes select debug port.
- MEM_RD  out  1  debug memory read strobe.
- MEM_WR  out  1  debug memory write strobe.
- MEM_READY  in  1  memory access complete.
- DEBUG_HALTED  out  1  status: CPU halted under debug control.
- DEBUG_ERR  out  1  sticky: memory timeout occurred; cleared by the next accepted request.

Behaviour:
- Reset (RESET low, async): state RUN; every output 0; timeout counter 0; DEBUG_ERR 0.
- RUN: CPU_HALT=0, BUS_GRANT=0. If DEBUG_STOPX=1, go to STOPPING.
- STOPPING: on CPU_INSTR_DONE=1, set CPU_HALT=1 and go to HALTED next cycle. If DEBUG_STOPX drops before the boundary, return to RUN.
- HALTED:
  - CPU_HALT=1, BUS_GRANT=1, DEBUG_HALTED=1.
  - On DEBUG_REQX=1, latch DEBUG_OPX, clear DEBUG_ERR, go to EXEC.
  - Requests arriving in RUN or STOPPING stay pending. They are not acknowledged until HALTED.
- EXEC, by latched opcode:
  - 0 NOP: ACK.
  - 1 LD_ADDR: DEBUG_ADDR_LDX=1 for one cycle, then ACK.
  - 2 RD_MEM: MEM_RD=1 until MEM_READY. In the MEM_READY cycle pulse DEBUG_DOUT_LDX. Next cycle pulse DEBUG_ADDR_INCX, then ACK.
  - 3 WR_MEM: MEM_WR=1 until MEM_READY. Next cycle pulse DEBUG_ADDR_INCX, then ACK.
  - 4 RD_SRC: DEBUG_DOUT_LDX=1 for one cycle, then ACK.
  - 5 STEP: CPU_HALT=0 and BUS_GRANT=0 until CPU_INSTR_DONE, then re-halt and ACK. Latency is one instruction plus 2 cycles.
  - 6 RESUME: ACK, then go to RUN once ACK completes. Ignored (plain ACK) while DEBUG_STOPX=1.
  - 7: reserved, treated as NOP.
- Memory timeout: count cycles with MEM_RD or MEM_WR asserted. When the count reaches MEM_TIMEOUT and MEM_READY is still 0:
  - drop the strobe and set DEBUG_ERR;
  - skip DOUT_LDX and ADDR_INCX;
  - ACK.
- Timing: MEM_READY in the same cycle as the strobe's first cycle gives a read latency of 3 cycles from EXEC entry to ACK.
- ACK: DEBUG_ACKX=1 for exactly one cycle, then WAIT_REQ_LOW. Stay there until DEBUG_REQX=0, then return to HALTED (or RUN after RESUME). A level REQX never triggers two operations.
- Strobes are mutually exclusive cycle by cycle; never assert DEBUG_ADDR_LDX and DEBUG_ADDR_INCX together.
- BUS_GRANT changes only in HALTED/WAIT_REQ_LOW/RUN transitions. Never toggle it while MEM_RD or MEM_WR is high.
- Reset mid-operation: strobes drop immediately (async). The CPU is released (state RUN); the pending request is discarded.

Decomposition:
- Shared constants file holds:
  - DEBUG_OP_* encodings (NOP, LD_ADDR, RD_MEM, WR_MEM, RD_SRC, STEP, RESUME);
  - DBGSEQ_* state encodings (RUN, STOPPING, HALTED, EXEC, MEM, POST, ACK, WAIT_REQ_LOW, STEP).
- One natural sub-module: dbg_timeout_counter, a 4-bit down-counter with load and expiry flag.

Test Plan:
- STOPX=1 in RUN, CPU_INSTR_DONE after 4 cycles -> CPU_HALT=1 and DEBUG_HALTED=1 on the following cycle, BUS_GRANT=1; no ACK generated.
- Halted, REQX=1 with OPX=1 -> exactly one ADDR_LDX pulse, then one ACKX pulse; REQX held 10 cycles -> no second ADDR_LDX; REQX=0 -> HALTED.
- Halted, OPX=2, MEM_READY after 2 cycles -> MEM_RD high 3 cycles, DOUT_LDX in the READY cycle, ADDR_INCX next cycle, then ACKX; DEBUG_ERR=0.
- Halted, OPX=3, MEM_READY never -> MEM_WR high 15 cycles then low, DEBUG_ERR=1, no ADDR_INCX, ACKX pulses; next REQX (OPX=0) clears DEBUG_ERR.
- Halted, OPX=5 -> CPU_HALT=0 until CPU_INSTR_DONE, then CPU_HALT=1 and ACKX; STOPX=0 then OPX=6 -> ACKX, then state RUN with CPU_HALT=0 and BUS_GRANT=0.
- RESET asserted mid RD_MEM (MEM_RD=1) -> MEM_RD, CPU_HALT, BUS_GRANT and ACKX go 0 without waiting for a clock edge; after release state is RUN.
